alien_march_ctrl: RTL and testbench
===================================

ALIEN_MARCH_CTRL -- requirements
Module: alien_march_ctrl

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, clk cycles per second.
REQ-002 Parameter X_MAX, default 15, rightmost horizontal step index of the formation.
REQ-003 Parameter ROW_LIMIT, default 40, descent row at which the game is lost.
REQ-004 Parameter YW, default 6, width of y_pos; ROW_LIMIT SHALL be < 2**YW.
REQ-005 clk input 1: rising-edge clock.
REQ-006 reset input 1: reset, synchronous, active-low.
REQ-007 start input 1: one-cycle pulse, home base drawn; begins marching.
REQ-008 pause input 1: high freezes the tick counter.
REQ-009 speed_level input 2: 0..3, selects the step period.
REQ-010 draw_done input 1: VGA finished redrawing the formation.
REQ-011 x_pos output $clog2(X_MAX+1): current horizontal step.
REQ-012 y_pos output YW: current descent row.
REQ-013 dir_right output 1: 1 when the formation is marching right.
REQ-014 draw_en output 1: redraw request, held until draw_done.
REQ-015 game_over output 1: sticky loss flag.
REQ-016 busy output 1: high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, COUNT, DRAW, OVER.
REQ-018 IDLE -> COUNT on start; the counter loads PERIOD(speed_level)-1; start is ignored in all other states.
REQ-019 PERIOD(L) = (CLOCK_FREQUENCY*4) >> L cycles: level 0 = 4 s, 1 = 2 s, 2 = 1 s, 3 = 0.5 s; arithmetic is 32-bit unsigned.
REQ-020 In COUNT, each cycle with pause low decrements the counter; with pause high, counter and state hold.
REQ-021 A tick occurs in the COUNT cycle where the counter is 0 and pause is low.
REQ-022 On a tick, when dir_right=1 and x_pos<X_MAX, x_pos increments.
REQ-023 On a tick, when dir_right=0 and x_pos>0, x_pos decrements.
REQ-024 On a tick at an edge (right edge with x_pos=X_MAX, or left edge with x_pos=0): y_pos increments, dir_right toggles, x_pos is unchanged.
REQ-025 After a tick, the state goes to DRAW and draw_en=1 from the next cycle.
REQ-026 Exception: when the tick makes y_pos equal ROW_LIMIT, the state goes to OVER instead of DRAW.
REQ-027 DRAW: draw_en held high and the counter is frozen.
REQ-028 In DRAW, on draw_done: draw_en falls the next cycle, the counter reloads PERIOD(current speed_level)-1, and the state returns to COUNT.
REQ-029 draw_done outside DRAW is ignored.
REQ-030 speed_level is sampled only at reload; a change mid-count does not affect the current period.
REQ-031 OVER: game_over=1, draw_en=0, positions frozen; the FSM leaves OVER only on reset.
REQ-032 When pause and the tick condition coincide, pause wins and no tick occurs.

Reset
REQ-033 When reset is low at a clk edge: state becomes IDLE and counter 0.
REQ-034 Reset output values: x_pos=0, y_pos=0, dir_right=1, draw_en=0, game_over=0, busy=0.
REQ-035 Reset mid-operation, in any state including DRAW or OVER, takes effect on that edge.
REQ-036 Reset has priority over start, pause and draw_done.

Structure
REQ-037 A shared package alien_pkg SHALL hold the FSM state enum, the speed-level constants and the PERIOD function.
REQ-038 The tick counter SHALL be the sub-module march_rate_div, with ports clk, reset, load, hold, period, tick.
REQ-039 The FSM and position registers SHALL be in alien_march_ctrl.

Verification (CLOCK_FREQUENCY=8, X_MAX=3, ROW_LIMIT=2)
REQ-040 Start pulse with speed_level=0, draw_done returned 1 cycle after each draw_en -> first draw_en rises 33 cycles after start, x_pos=1.
REQ-041 speed_level=3, continuous draw_done handshakes -> x_pos sequence 1,2,3,3(y=1,dir_right=0),2,1,0,0(y=2) -> game_over=1, draw_en never rises again.
REQ-042 pause high for 10 cycles mid-count -> tick delayed by exactly 10 cycles; positions unchanged during the pause.
REQ-043 draw_done withheld for 50 cycles -> draw_en stays high, no further tick, x_pos stable.
REQ-044 speed_level changed from 0 to 3 mid-count -> current period stays 32 cycles, the next period is 4 cycles.
REQ-045 reset low while in DRAW and while in OVER -> next cycle all outputs at their reset values; start then restarts from x_pos=0.

Source files
------------

// File: rtl/alien_pkg.sv
// Shared definitions for the alien formation march controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: FSM state enum, speed-level codes, step-period function.
package alien_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DRAW  = 2'd2,
    ST_OVER  = 2'd3
  } march_state_t;

  // speed_level codes: each level halves the step period.
  localparam logic [1:0] SPEED_4S     = 2'd0;
  localparam logic [1:0] SPEED_2S     = 2'd1;
  localparam logic [1:0] SPEED_1S     = 2'd2;
  localparam logic [1:0] SPEED_HALF_S = 2'd3;

  // Step period in clock cycles: (clk_freq * 4) >> level, 32-bit unsigned.
  function automatic logic [31:0] march_period(input logic [31:0] clk_freq,
                                               input logic [1:0]  level);
    logic [31:0] base;
    base = clk_freq << 2;
    return base >> level;
  endfunction

endpackage

// File: rtl/march_rate_div.sv
// Step-rate divider: down-counter that flags a tick when it reaches zero.
// Latency: tick is combinational from the count; a load takes effect next cycle.
// Backpressure: hold freezes the count and suppresses tick.
// Ports: clk, reset (sync, active-low), load (reload period-1), hold,
//        period (cycles per step), tick (count is zero and not held).
module march_rate_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= period - 32'd1;
    end else if (!hold && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  // Count parks at zero after a tick; the owner holds or reloads it.
  assign tick = !hold && (count == 32'd0);

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller: steps the formation across and down.
// Latency: position updates on the tick edge; draw_en/game_over follow the state register (next cycle).
// Backpressure: draw_en is held until draw_done; the step timer is frozen meanwhile and while pause is high.
// Ports: clk, reset (sync, active-low), start, pause, speed_level[1:0], draw_done;
//        x_pos, y_pos, dir_right, draw_en, game_over, busy.
module alien_march_ctrl
  import alien_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int X_MAX           = 15,
  parameter int ROW_LIMIT       = 40,
  parameter int YW              = 6,
  localparam int XW             = $clog2(X_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic [1:0]    speed_level,
  input  logic          draw_done,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          dir_right,
  output logic          draw_en,
  output logic          game_over,
  output logic          busy
);

  localparam logic [XW-1:0] X_TOP   = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIMIT = YW'(ROW_LIMIT);

  march_state_t  state, state_nxt;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          dir_nxt;

  logic          load;
  logic          hold;
  logic          tick;
  logic [31:0]   period;

  // speed_level only matters at reload, so it is applied combinationally to load.
  assign period = march_period(32'(CLOCK_FREQUENCY), speed_level);
  assign load   = ((state == ST_IDLE) && start) || ((state == ST_DRAW) && draw_done);
  assign hold   = pause || (state != ST_COUNT);

  march_rate_div u_rate_div (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .hold   (hold),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      x_pos     <= '0;
      y_pos     <= '0;
      dir_right <= 1'b1;
    end else begin
      state     <= state_nxt;
      x_pos     <= x_nxt;
      y_pos     <= y_nxt;
      dir_right <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_pos;
    y_nxt     = y_pos;
    dir_nxt   = dir_right;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (tick) begin
          if (dir_right && (x_pos != X_TOP)) begin
            x_nxt = x_pos + XW'(1);
          end else if (!dir_right && (x_pos != '0)) begin
            x_nxt = x_pos - XW'(1);
          end else begin
            // At an edge: drop one row and reverse, column unchanged.
            y_nxt   = y_pos + YW'(1);
            dir_nxt = !dir_right;
          end
          state_nxt = (y_nxt == Y_LIMIT) ? ST_OVER : ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (draw_done) state_nxt = ST_COUNT;
      end
      ST_OVER: begin
        state_nxt = ST_OVER;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign draw_en   = (state == ST_DRAW);
  assign game_over = (state == ST_OVER);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed bench for alien_march_ctrl with CLOCK_FREQUENCY=8, X_MAX=3, ROW_LIMIT=2.
// Step periods: level 0 = 32 cycles, level 3 = 4 cycles.
module tb_alien_march_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic [1:0] speed_level;
  logic       draw_done;
  logic [1:0] x_pos;
  logic [5:0] y_pos;
  logic       dir_right;
  logic       draw_en;
  logic       game_over;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n;

  alien_march_ctrl #(
    .CLOCK_FREQUENCY (8),
    .X_MAX           (3),
    .ROW_LIMIT       (2),
    .YW              (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .speed_level (speed_level),
    .draw_done   (draw_done),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .dir_right   (dir_right),
    .draw_en     (draw_en),
    .game_over   (game_over),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},    32'(x_pos), 32'd0);
    chk({tag, "_y"},    32'(y_pos), 32'd0);
    chk({tag, "_dir"},  32'(dir_right), 32'd1);
    chk({tag, "_den"},  32'(draw_en), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Advance until draw_en or game_over rises, bounded by limit; n counts edges.
  task automatic run_until_draw(input int limit);
    while (!(draw_en || game_over) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  // Return draw_done for one cycle, then time the next step.
  task automatic handshake_and_wait(input string tag, input int exp_n,
                                    input logic [1:0] ex, input logic [5:0] ey,
                                    input logic ed);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk({tag, "_den_low"}, 32'(draw_en), 32'd0);
    n = 0;
    run_until_draw(200);
    chk({tag, "_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_x"}, 32'(x_pos), 32'(ex));
    chk({tag, "_y"}, 32'(y_pos), 32'(ey));
    chk({tag, "_dir"}, 32'(dir_right), 32'(ed));
  endtask

  initial begin
    logic [1:0] seq_x [4];
    logic [5:0] seq_y [4];
    seq_x = '{2'd2, 2'd1, 2'd0, 2'd0};
    seq_y = '{6'd1, 6'd1, 6'd1, 6'd2};

    reset = 1'b0; start = 1'b0; pause = 1'b0; speed_level = 2'd0; draw_done = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b1;
    step();

    // First step at level 0: draw_en rises 33 cycles after the start cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    chk("start_busy", 32'(busy), 32'd1);
    run_until_draw(200);
    chk("first_draw_cycles", 32'(n), 32'd33);
    chk("first_draw_x", 32'(x_pos), 32'd1);
    chk("first_draw_y", 32'(y_pos), 32'd0);

    // draw_done withheld for 50 cycles: nothing moves.
    repeat (50) step();
    chk("stall_den", 32'(draw_en), 32'd1);
    chk("stall_x", 32'(x_pos), 32'd1);

    // Pause for 10 cycles mid-count delays the tick by exactly 10.
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk("pause_den_low", 32'(draw_en), 32'd0);
    repeat (10) step();
    pause = 1'b1;
    repeat (10) step();
    chk("pause_x", 32'(x_pos), 32'd1);
    chk("pause_den", 32'(draw_en), 32'd0);
    pause = 1'b0;
    n = 20;
    run_until_draw(200);
    chk("pause_cycles", 32'(n), 32'd42);
    chk("pause_x_after", 32'(x_pos), 32'd2);

    // Mid-count speed change (and an ignored start): period stays 32, next is 4.
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    n = 1;
    repeat (5) begin
      step();
      n++;
    end
    start = 1'b1;
    speed_level = 2'd3;
    step();
    n++;
    start = 1'b0;
    run_until_draw(200);
    chk("spd_cycles", 32'(n - 1), 32'd32);
    chk("spd_x", 32'(x_pos), 32'd3);
    handshake_and_wait("edge_r", 4, 2'd3, 6'd1, 1'b0);

    // March back left and down to the loss row.
    for (int i = 0; i < 4; i++) begin
      handshake_and_wait($sformatf("seq%0d", i), 4, seq_x[i], seq_y[i], (i == 3));
    end
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_den", 32'(draw_en), 32'd0);

    // OVER is sticky and ignores start/draw_done.
    for (int i = 0; i < 20; i++) begin
      draw_done = i[0];
      start = i[1];
      step();
    end
    draw_done = 1'b0;
    start = 1'b0;
    chk("over_hold_flag", 32'(game_over), 32'd1);
    chk("over_hold_den", 32'(draw_en), 32'd0);
    chk("over_hold_x", 32'(x_pos), 32'd0);
    chk("over_hold_y", 32'(y_pos), 32'd2);
    chk("over_busy", 32'(busy), 32'd1);

    // Reset out of OVER.
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_reset_vals("rst_over");

    // Restart at level 3 from x=0, then reset while in DRAW beats draw_done.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    run_until_draw(200);
    chk("restart_cycles", 32'(n), 32'd5);
    chk("restart_x", 32'(x_pos), 32'd1);
    chk("restart_den", 32'(draw_en), 32'd1);
    reset = 1'b0;
    draw_done = 1'b1;
    step();
    reset = 1'b1;
    chk_reset_vals("rst_draw");

    // draw_done in IDLE is ignored.
    repeat (3) step();
    draw_done = 1'b0;
    chk("idle_dd_busy", 32'(busy), 32'd0);
    chk("idle_dd_x", 32'(x_pos), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
